// File: rtl/interrupt_request_controller.sv
// interrupt_request_controller: fixed-priority IRQ collector driving a bounded interrupt pulse.
// Define IRQ_LEVEL_MODE_EN for level-sensitive sources (no latching, no software clear).
module interrupt_request_controller #(
    parameter int NUM_IRQ        = 4,
    parameter int PULSE_CYCLES   = 2,
    parameter int HOLDOFF_CYCLES = 8,
    localparam int ID_W          = $clog2(NUM_IRQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_IRQ-1:0] irq_in_i,
    input  logic [NUM_IRQ-1:0] irq_mask_i,
    input  logic [NUM_IRQ-1:0] irq_clear_i,
    output logic               interrupt_o,
    output logic [ID_W-1:0]    irq_id_o,
    output logic [NUM_IRQ-1:0] pending_o
);
    localparam int CNT_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ASSERT  = 2'd1;
    localparam logic [1:0] HOLDOFF = 2'd2;

    logic [NUM_IRQ-1:0] sync1_q, sync2_q, pending, eligible, dispatch_clr;
    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    id_q, id_d, winner;
    logic               int_q, int_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef IRQ_LEVEL_MODE_EN
    logic unused_level;
    assign unused_level = ^{irq_clear_i, dispatch_clr};
    assign pending      = sync2_q;
`else
    logic [NUM_IRQ-1:0] prev_q, pending_q, pending_d;
    // Set wins over any clear so a request arriving with a clear is never lost.
    assign pending_d = (sync2_q & ~prev_q) | (pending_q & ~irq_clear_i & ~dispatch_clr);
    assign pending   = pending_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            prev_q    <= sync2_q;
            pending_q <= pending_d;
        end
    end
`endif

    assign eligible = pending & irq_mask_i;

    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (eligible[i]) winner = ID_W'(i);
    end

    assign dispatch_clr = (state_q == IDLE && |eligible) ?
                          ({{(NUM_IRQ-1){1'b0}}, 1'b1} << winner) : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        case (state_q)
            IDLE: if (|eligible) begin
                state_d = ASSERT;
                id_d    = winner;
                cnt_d   = CNT_W'(PULSE_CYCLES - 1);
            end
            ASSERT: if (cnt_q == '0) begin
                state_d = HOLDOFF;
                cnt_d   = CNT_W'(HOLDOFF_CYCLES - 1);
            end else cnt_d = cnt_q - CNT_W'(1);
            HOLDOFF: if (cnt_q == '0) state_d = IDLE;
                     else cnt_d = cnt_q - CNT_W'(1);
            default: state_d = IDLE;
        endcase
    end

    assign int_d = (state_d == ASSERT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            int_q   <= int_d;
        end
    end

    assign interrupt_o = int_q;
    assign irq_id_o    = id_q;
    assign pending_o   = pending;
endmodule
